// File: rtl/md5_core_arbiter.sv
// rtl/md5_core_arbiter.sv - two-requester round-robin front end for one shared MD5 core
// Grants a padded block, pulses start, waits for the digest under a watchdog, returns done/err.
module md5_core_arbiter #(
  parameter int unsigned TIMEOUT = 256,
  parameter int unsigned CW      = 16
) (
  input  logic         wb_clk_i,
  input  logic         wb_rst_i,
  input  logic [1:0]   req_valid_i,
  input  logic [511:0] req0_block_i,
  input  logic [511:0] req1_block_i,
  output logic [1:0]   req_ack_o,
  output logic [1:0]   req_done_o,
  output logic [1:0]   req_err_o,
  output logic [127:0] hash_o,
  output logic         busy_o,
  output logic [1:0]   grant_o,
  output logic [511:0] core_msg_o,
  output logic         core_start_o,
  input  logic         core_ready_i,
  input  logic [127:0] core_hash_i,
  input  logic         core_valid_i
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE,
    S_ERR
  } state_e;

  localparam logic [CW-1:0] WD_LOAD = CW'(TIMEOUT);
  localparam logic [CW-1:0] WD_ONE  = CW'(1);

  state_e         state_q, state_d;
  logic [1:0]     ack_q, ack_d;
  logic [1:0]     done_q, done_d;
  logic [1:0]     err_q, err_d;
  logic [1:0]     grant_q, grant_d;
  logic [127:0]   hash_q, hash_d;
  logic [511:0]   msg_q, msg_d;
  logic           start_q, start_d;
  logic           prio_q, prio_d;
  logic [CW-1:0]  wd_q, wd_d;
  logic           winner;

  // Pointer only matters under contention; a lone requester always wins.
  assign winner = (req_valid_i == 2'b11) ? prio_q : req_valid_i[1];

  always_comb begin
    state_d = state_q;
    ack_d   = 2'b00;
    done_d  = 2'b00;
    err_d   = 2'b00;
    start_d = 1'b0;
    grant_d = grant_q;
    hash_d  = hash_q;
    msg_d   = msg_q;
    prio_d  = prio_q;
    wd_d    = wd_q;
    case (state_q)
      S_IDLE: begin
        if (core_ready_i && (req_valid_i != 2'b00)) begin
          msg_d   = winner ? req1_block_i : req0_block_i;
          grant_d = winner ? 2'b10 : 2'b01;
          ack_d   = winner ? 2'b10 : 2'b01;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        start_d = 1'b1;
        wd_d    = WD_LOAD;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A digest arriving on the expiry cycle still counts as success.
        if (core_valid_i) begin
          hash_d  = core_hash_i;
          done_d  = grant_q;
          state_d = S_DONE;
        end else if (wd_q == WD_ONE) begin
          err_d   = grant_q;
          state_d = S_ERR;
        end else begin
          wd_d = wd_q - WD_ONE;
        end
      end
      S_DONE, S_ERR: begin
        prio_d  = ~grant_q[1];
        grant_d = 2'b00;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      state_q <= S_IDLE;
      ack_q   <= 2'b00;
      done_q  <= 2'b00;
      err_q   <= 2'b00;
      grant_q <= 2'b00;
      hash_q  <= '0;
      msg_q   <= '0;
      start_q <= 1'b0;
      prio_q  <= 1'b0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      done_q  <= done_d;
      err_q   <= err_d;
      grant_q <= grant_d;
      hash_q  <= hash_d;
      msg_q   <= msg_d;
      start_q <= start_d;
      prio_q  <= prio_d;
      wd_q    <= wd_d;
    end
  end

  assign req_ack_o    = ack_q;
  assign req_done_o   = done_q;
  assign req_err_o    = err_q;
  assign hash_o       = hash_q;
  assign busy_o       = (state_q != S_IDLE);
  assign grant_o      = grant_q;
  assign core_msg_o   = msg_q;
  assign core_start_o = start_q;

endmodule

// File: doc/md5_core_arbiter.md
Name: md5_core_arbiter

Overview:
- Two-requester round-robin scheduler in front of one shared MD5 core (512-bit padded block in, 128-bit digest out).
- Takes a block from the granted requester, issues a single start pulse to the core, and waits for the digest.
- Returns the digest and a done pulse to that requester.
- A watchdog aborts a job the core never finishes.
- Sits between two Wishbone register front-ends and the MD5 core.

Parameters:
- TIMEOUT, 256, max cycles in WAIT before abort; legal range 2..65535.
- CW, 16, width of watchdog counter; must satisfy 2^CW > TIMEOUT.

Ports:
- wb_clk_i  in  1  single clock; all logic rising-edge.
- wb_rst_i  in  1  asynchronous, active-low reset (0 = reset).
- req_valid_i  in  2  per-requester block-pending request, level.
- req0_block_i  in  512  requester 0 padded block.
- req1_block_i  in  512  requester 1 padded block.
- req_ack_o  out  2  one-cycle pulse: block captured, requester may drop valid.
- req_done_o  out  2  one-cycle pulse: digest valid on hash_o.
- req_err_o  out  2  one-cycle pulse: job aborted by watchdog.
- hash_o  out  128  last captured digest, held until next completion.
- busy_o  out  1  high in any state except IDLE.
- grant_o  out  2  one-hot owner of current job; 00 in IDLE.
- core_msg_o  out  512  registered block to core.
- core_start_o  out  1  one-cycle start pulse to core.
- core_ready_i  in  1  core idle/able to accept.
- core_hash_i  in  128  core digest.
- core_valid_i  in  1  core digest-valid.

Behaviour:
- Reset values (asynchronous on wb_rst_i low): state=IDLE; all outputs 0; core_msg_o=0; hash_o=0; priority pointer=0 (requester 0 favoured); watchdog=0. The block leaves reset on the first clock edge after wb_rst_i rises.
- States: IDLE, ISSUE, WAIT, DONE, ERR.
- IDLE:
  - If core_ready_i=1 and any req_valid_i bit set, pick a winner.
  - Winner rule: if only one requests, it wins; if both, the one the priority pointer names wins.
  - On the edge: core_msg_o<=winner block; grant_o<=winner one-hot; req_ack_o[winner]<=1 for one cycle; go ISSUE.
  - If core_ready_i=0, stay in IDLE; no ack.
- ISSUE (exactly 1 cycle): core_start_o=1; watchdog<=TIMEOUT; go WAIT.
- WAIT:
  - core_valid_i=1: hash_o<=core_hash_i; go DONE.
  - Otherwise, watchdog=1: go ERR.
  - Otherwise: watchdog decrements.
  - core_valid_i has priority over expiry in the same cycle.
- DONE (1 cycle): req_done_o[owner]=1; priority pointer<=other requester; grant_o<=0 on exit; go IDLE.
- ERR (1 cycle): req_err_o[owner]=1; hash_o unchanged; priority pointer<=other requester; go IDLE.
- Latency, valid to ack: ack is seen 1 cycle after req_valid_i is sampled with core_ready_i=1. core_start_o is asserted the cycle after ack.
- Latency, done: req_done_o is asserted 1 cycle after core_valid_i is sampled in WAIT.
- Minimum spacing between two back-to-back jobs: core latency + 4 cycles.
- Output registration: core_start_o, req_* pulses and hash_o come from registers; no combinational path from inputs to outputs.
- core_valid_i outside WAIT (including the ISSUE cycle) is ignored.
- req_valid_i dropped before ack: the request is simply not served; no error.
- req_valid_i held after done: treated as a new request; no dedup.
- Blocks are captured at grant; later changes on reqN_block_i do not affect the running job.
- Reset asserted mid-job: abort immediately to reset values with no done/err pulse; the core is reset separately by its own reset.

Test Plan:
- Single job: req_valid_i=01, block0=MD5-padded "abc", stub core returns 900150983cd24fb0d6963f7d28e17f72 after 10 cycles → ack[0] 1 cycle after request, one start pulse, done[0] 1 cycle after core_valid_i, hash_o equals digest.
- Contention: req_valid_i=11 held for 4 jobs → grant order 0,1,0,1; exactly one ack and one done per job; no overlapping starts.
- core_ready_i=0 for 20 cycles with req_valid_i=10 → no ack and busy_o=0; ack 1 cycle after core_ready_i rises.
- Watchdog: TIMEOUT=8, core never asserts valid → req_err_o[owner] pulse 8 cycles after start; hash_o unchanged; next request is granted to the other requester.
- Race: core_valid_i on the same cycle the watchdog reaches 1 → done, not err.
- Reset mid-WAIT: wb_rst_i low for 1 cycle → all outputs 0 immediately; no done/err; a fresh request afterwards completes normally.
